// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, queued writer pixels fill the gaps.
// Writes pass through an ordered FIFO and can be held off until blanking (tear-free mode).
module vram_arbiter #(
    parameter bit WR_BLANK_ONLY = 1'b0,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_active,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    input  logic        i_screenend,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [8:0]  i_wr_x,
    input  logic [7:0]  i_wr_y,
    input  logic [7:0]  i_wr_data,
    output logic [16:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic [7:0]  o_pix,
    output logic        o_wr_err,
    output logic [15:0] o_stall_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRD, WR} state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [16:0] r_fifoAddr [FIFO_DEPTH];
    logic [7:0]  r_fifoData [FIFO_DEPTH];

    logic [16:0] r_memAddr;
    logic        r_memWe;
    logic [7:0]  r_memWdata;
    logic [7:0]  r_pix;
    logic        r_rdValid;
    logic        r_blankSeen;
    logic        r_wrErr;
    logic [15:0] r_stallCnt;

    logic        w_empty;
    logic        w_full;
    logic        w_accept;
    logic        w_inRange;
    logic        w_push;
    logic        w_pop;
    logic        w_dispRead;
    logic        w_wrPermit;
    logic [8:0]  w_dispY;
    logic [9:0]  w_dispX;
    logic [16:0] w_dispAddr;
    logic [16:0] w_wrAddr;

    // Extra pointer bit separates full from empty when the indices match
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_wr_ready = !w_full && !i_rst;

    assign w_accept   = i_wr_valid && o_wr_ready;
    assign w_inRange  = (i_wr_x < 9'd320) && (i_wr_y < 8'd240);
    assign w_push     = w_accept && w_inRange;
    assign w_pop      = (w_nextState == WR);
    assign w_dispRead = i_pix_stb && i_active;
    assign w_wrPermit = !WR_BLANK_ONLY || !i_active;

    // 640x480 timing maps onto the 320x240 frame by halving both coordinates
    assign w_dispY    = i_y >> 1;
    assign w_dispX    = i_x >> 1;
    assign w_dispAddr = ({8'd0, w_dispY} << 8) + ({8'd0, w_dispY} << 6) + {7'd0, w_dispX};
    assign w_wrAddr   = ({9'd0, i_wr_y} << 8) + ({9'd0, i_wr_y} << 6) + {8'd0, i_wr_x};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = IDLE;
        if (w_dispRead) begin
            w_nextState = DRD;
        end else if (!w_empty && w_wrPermit) begin
            w_nextState = WR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
        end else begin
            r_memWe <= (w_nextState == WR);
            case (w_nextState)
                DRD: r_memAddr <= w_dispAddr;
                WR: begin
                    r_memAddr  <= r_fifoAddr[r_rdPtr[AW-1:0]];
                    r_memWdata <= r_fifoData[r_rdPtr[AW-1:0]];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr[AW-1:0]] <= w_wrAddr;
            r_fifoData[r_wrPtr[AW-1:0]] <= i_wr_data;
        end
    end

    // Blanking forces black once; read data lands two cycles after the strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdValid   <= 1'b0;
            r_pix       <= '0;
            r_blankSeen <= 1'b1;
        end else begin
            r_rdValid <= (r_state == DRD);
            if (i_pix_stb && !i_active && !r_blankSeen) begin
                r_pix       <= '0;
                r_blankSeen <= 1'b1;
            end else begin
                if (r_rdValid) begin
                    r_pix <= i_mem_rdata;
                end
                if (w_dispRead) begin
                    r_blankSeen <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrErr    <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            r_wrErr <= w_accept && !w_inRange;
            if (i_screenend) begin
                r_stallCnt <= '0;
            end else if (!w_empty && (r_state != WR) && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
        end
    end

    assign o_mem_addr  = r_memAddr;
    assign o_mem_we    = r_memWe;
    assign o_mem_wdata = r_memWdata;
    assign o_pix       = r_pix;
    assign o_wr_err    = r_wrErr;
    assign o_stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter in tear-free mode, with a queue-based
// reference model compared every cycle plus hand-computed spot checks.
module tb_vram_arbiter;
    localparam int DEPTH = 4;
    localparam bit BLANK = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        active = 1'b0;
    logic [9:0]  xx = '0;
    logic [8:0]  yy = '0;
    logic        screenend = 1'b0;
    logic        wv = 1'b0;
    logic [8:0]  wx = '0;
    logic [7:0]  wy = '0;
    logic [7:0]  wd = '0;
    logic [7:0]  rdata = 8'h5A;

    logic        o_wr_ready;
    logic [16:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  o_pix;
    logic        o_wr_err;
    logic [15:0] o_stall_cnt;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    vram_arbiter #(.WR_BLANK_ONLY(BLANK), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_active(active),
        .i_x(xx), .i_y(yy), .i_screenend(screenend),
        .i_wr_valid(wv), .o_wr_ready(o_wr_ready),
        .i_wr_x(wx), .i_wr_y(wy), .i_wr_data(wd),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(rdata), .o_pix(o_pix), .o_wr_err(o_wr_err), .o_stall_cnt(o_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue, the command for the next
    // cycle is chosen by the priority rules, read data lands by cycle count.
    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         mq[$];
    wr_t         mEntry;
    logic [16:0] mAddr = '0;
    logic        mWe = 1'b0;
    logic [7:0]  mWdata = '0;
    logic [7:0]  mPix = '0;
    logic        mErr = 1'b0;
    int          mStall = 0;
    longint      cyc = 0;
    longint      loadAt = -1;
    bit          blankDone = 1'b1;
    bit          canTake;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            mAddr = '0; mWe = 1'b0; mWdata = '0; mPix = '0; mErr = 1'b0;
            mStall = 0; loadAt = -1; blankDone = 1'b1;
        end else begin
            canTake = (mq.size() < DEPTH);
            if (stb && !active && !blankDone) begin
                mPix = '0;
                blankDone = 1'b1;
            end else if (cyc == loadAt) begin
                mPix = rdata;
            end
            if (stb && active) blankDone = 1'b0;
            if (screenend) mStall = 0;
            else if (mq.size() > 0 && !mWe && mStall < 65535) mStall++;
            if (stb && active) begin
                mWe = 1'b0;
                mAddr = 17'((int'(yy) / 2) * 320 + int'(xx) / 2);
                loadAt = cyc + 2;
            end else if (mq.size() > 0 && (!BLANK || !active)) begin
                mEntry = mq.pop_front();
                mWe = 1'b1;
                mAddr = mEntry.addr;
                mWdata = mEntry.data;
            end else begin
                mWe = 1'b0;
            end
            mErr = 1'b0;
            if (wv && canTake) begin
                if (int'(wx) < 320 && int'(wy) < 240) begin
                    mEntry.addr = 17'(int'(wy) * 320 + int'(wx));
                    mEntry.data = wd;
                    mq.push_back(mEntry);
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("mem_we", 32'(o_mem_we), 32'(mWe));
            checkOutput("mem_addr", 32'(o_mem_addr), 32'(mAddr));
            if (mWe) checkOutput("mem_wdata", 32'(o_mem_wdata), 32'(mWdata));
            checkOutput("pix", 32'(o_pix), 32'(mPix));
            checkOutput("wr_err", 32'(o_wr_err), 32'(mErr));
            checkOutput("stall_cnt", 32'(o_stall_cnt), 32'(mStall));
            checkOutput("wr_ready", 32'(o_wr_ready), 32'(!rst && mq.size() < DEPTH));
        end
    end

    task automatic applyStimulus(input bit s, input bit a, input int px, input int py,
                                 input bit v, input int qx, input int qy, input int qd,
                                 input bit se);
        stb = s; active = a; xx = 10'(px); yy = 9'(py);
        wv = v; wx = 9'(qx); wy = 8'(qy); wd = 8'(qd); screenend = se;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit a);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, a, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle(1, 1'b0);
        checking = 1'b1;
        idle(2, 1'b0);
        checkOutput("rst_we", 32'(o_mem_we), 32'd0);
        checkOutput("rst_addr", 32'(o_mem_addr), 32'd0);
        checkOutput("rst_pix", 32'(o_pix), 32'd0);
        checkOutput("rst_stall", 32'(o_stall_cnt), 32'd0);
        checkOutput("rst_ready", 32'(o_wr_ready), 32'd0);
        rst = 1'b0;
        idle(1, 1'b0);
        checkOutput("ready_after_rst", 32'(o_wr_ready), 32'd1);

        // Active strobe at (10,4): read of 645, pixel three edges later
        rdata = 8'h5A;
        applyStimulus(1'b1, 1'b1, 10, 4, 1'b0, 0, 0, 0, 1'b0);
        checkOutput("drd_we", 32'(o_mem_we), 32'd0);
        checkOutput("drd_addr", 32'(o_mem_addr), 32'd645);
        idle(1, 1'b1);
        checkOutput("pix_not_yet", 32'(o_pix), 32'd0);
        idle(1, 1'b1);
        checkOutput("pix_loaded", 32'(o_pix), 32'h5A);

        // Corner write while idle in blanking
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 319, 239, 8'h33, 1'b0);
        checkOutput("wr_not_early", 32'(o_mem_we), 32'd0);
        idle(1, 1'b0);
        checkOutput("wr_we", 32'(o_mem_we), 32'd1);
        checkOutput("wr_addr", 32'(o_mem_addr), 32'd76799);
        checkOutput("wr_data", 32'(o_mem_wdata), 32'h33);

        // Blank strobe forces black
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        checkOutput("blank_pix", 32'(o_pix), 32'd0);

        // Out-of-range write
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 320, 0, 8'h11, 1'b0);
        checkOutput("err_pulse", 32'(o_wr_err), 32'd1);
        idle(1, 1'b0);
        checkOutput("err_cleared", 32'(o_wr_err), 32'd0);
        checkOutput("err_no_write", 32'(o_mem_we), 32'd0);
        checkOutput("stall_one", 32'(o_stall_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
        checkOutput("stall_clear", 32'(o_stall_cnt), 32'd0);

        // Six back-to-back writes during active video: only four fit, none issue
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 0, 0, 1'b1, i * 10, i + 1, 8'hA0 + i, 1'b0);
        checkOutput("full_ready", 32'(o_wr_ready), 32'd0);
        checkOutput("full_no_we", 32'(o_mem_we), 32'd0);
        checkOutput("full_stall", 32'(o_stall_cnt), 32'd5);
        idle(1, 1'b0);
        checkOutput("drain0_addr", 32'(o_mem_addr), 32'd320);
        checkOutput("drain0_data", 32'(o_mem_wdata), 32'hA0);
        idle(1, 1'b0);
        checkOutput("drain1_addr", 32'(o_mem_addr), 32'd650);
        checkOutput("drain1_data", 32'(o_mem_wdata), 32'hA1);
        idle(4, 1'b0);

        // Strobe coinciding with a write: read first, write next cycle
        rdata = 8'hC3;
        applyStimulus(1'b1, 1'b1, 100, 50, 1'b1, 5, 6, 8'h77, 1'b0);
        checkOutput("coin_drd_we", 32'(o_mem_we), 32'd0);
        checkOutput("coin_drd_addr", 32'(o_mem_addr), 32'd8050);
        idle(1, 1'b0);
        checkOutput("coin_wr_we", 32'(o_mem_we), 32'd1);
        checkOutput("coin_wr_addr", 32'(o_mem_addr), 32'd1925);
        checkOutput("coin_wr_data", 32'(o_mem_wdata), 32'h77);
        idle(1, 1'b0);
        checkOutput("coin_pix", 32'(o_pix), 32'hC3);

        // Reset with queued writes and a read in flight
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 0, 0, 1'b1, i, i, 8'h50 + i, 1'b0);
        applyStimulus(1'b1, 1'b1, 20, 20, 1'b0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        idle(2, 1'b1);
        checkOutput("mid_rst_ready", 32'(o_wr_ready), 32'd0);
        checkOutput("mid_rst_we", 32'(o_mem_we), 32'd0);
        rst = 1'b0;
        idle(4, 1'b0);
        checkOutput("post_rst_we", 32'(o_mem_we), 32'd0);
        checkOutput("post_rst_pix", 32'(o_pix), 32'd0);
        checkOutput("post_rst_ready", 32'(o_wr_ready), 32'd1);
        idle(2, 1'b0);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter WR_BLANK_ONLY, default 0; when 1, writes are granted only while i_active=0 (tear-free mode).
REQ-002 Parameter FIFO_DEPTH, default 4; write-FIFO entries, power of two, minimum 2.
REQ-003 i_clk  in  1  system clock; only clock, rising-edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_pix_stb  in  1  pixel strobe, single-cycle pulse, at least 2 clocks apart.
REQ-006 i_active  in  1  timing generator active-video flag.
REQ-007 i_x  in  10  current pixel column, 0..639.
REQ-008 i_y  in  9  current pixel row, 0..479.
REQ-009 i_screenend  in  1  single-cycle end-of-frame pulse from the timing generator.
REQ-010 i_wr_valid / o_wr_ready  in/out  1/1  writer handshake; transfer when both are high on a clock edge.
REQ-011 i_wr_x  in  9, i_wr_y  in  8, i_wr_data  in  8  writer pixel coordinate (320x240 space) and colour.
REQ-012 o_mem_addr  out  17, o_mem_we  out  1, o_mem_wdata  out  8  single-port VRAM command, registered.
REQ-013 i_mem_rdata  in  8  VRAM read data, valid the clock after a read command.
REQ-014 o_pix  out  8  pixel colour to DAC, held between updates.
REQ-015 o_wr_err  out  1  one-cycle pulse: accepted write had an out-of-range coordinate.
REQ-016 o_stall_cnt  out  16  saturating count of cycles with FIFO non-empty but write not granted.

Function
REQ-017 Display address SHALL be (i_y>>1)*320 + (i_x>>1), 17-bit, sampled on the cycle i_pix_stb=1 and i_active=1 (cycle N).
REQ-018 Write address SHALL be i_wr_y*320 + i_wr_x, computed in 17 bits as (y<<8)+(y<<6)+x, with no truncation.
REQ-019 An accepted write with i_wr_x>=320 or i_wr_y>=240 SHALL NOT enter the FIFO; o_wr_err SHALL pulse in the following cycle.
REQ-020 o_wr_ready SHALL be 1 when the FIFO is not full and the block is not in reset; it is combinational from FIFO occupancy only.
REQ-021 The FSM has states IDLE, DRD and WR; the state names the command driven on the memory port this cycle.
REQ-022 Next-state priority: pending display read -> DRD; else FIFO non-empty and write permitted -> WR (pop one entry); else IDLE.
REQ-023 A display read SHALL always be issued in cycle N+1 (o_mem_we=0, o_mem_addr=display address); a write never delays it.
REQ-024 o_pix SHALL load i_mem_rdata at the end of cycle N+2, so o_pix changes on the edge after N+2, three clocks after the strobe edge.
REQ-025 A WR command SHALL be permitted in cycle N+2 (read data already in flight).
REQ-026 Write permitted = (WR_BLANK_ONLY==0) or (i_active==0), evaluated on the cycle the next state is selected.
REQ-027 Strobes with i_active=0 SHALL NOT issue reads; o_pix SHALL be forced to 0 on the first such strobe.
REQ-028 An entry written into the FIFO on cycle T SHALL NOT be popped before T+1 (no bypass).
REQ-029 A push and a pop in the same cycle SHALL both occur; occupancy is unchanged.
REQ-030 The FIFO SHALL preserve order; pointers wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-031 o_stall_cnt SHALL increment when the FIFO is non-empty and the state is not WR, SHALL saturate at 0xFFFF, and SHALL clear to 0 on i_screenend; clear wins over increment.
REQ-032 In IDLE, o_mem_we=0 and o_mem_addr holds its previous value.

Reset
REQ-033 While i_rst=1: FSM=IDLE, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_pix=0, o_wr_err=0, o_stall_cnt=0, FIFO empty, o_wr_ready=0.
REQ-034 Reset mid-operation SHALL discard FIFO contents and any in-flight read; o_pix stays 0 until the first active strobe after reset.

Verification
REQ-035 Active strobe at i_x=10, i_y=4, i_mem_rdata=0x5A -> read at addr 645 in N+1, o_pix=0x5A after edge N+3.
REQ-036 Write (x=319, y=239, data=0x33) while idle -> WR with addr 76799, we=1, wdata=0x33, no earlier than 2 clocks after acceptance.
REQ-037 Write (x=320, y=0) -> not queued, o_wr_err pulses once, FIFO occupancy unchanged.
REQ-038 6 back-to-back writes with WR_BLANK_ONLY=1 during active video -> o_wr_ready drops after 4; 0 writes issued; o_stall_cnt counts up; on blanking, writes drain in order.
REQ-039 Active strobe coincides with a FIFO-ready write -> DRD in N+1, write in N+2, both addresses correct.
REQ-040 Assert i_rst with 3 entries queued -> FIFO empty, o_mem_we=0; after release, no stale writes are issued.
